// File: rtl/score_bcd_display.sv
// rtl/score_bcd_display.sv - score to 5-digit seven-segment display with high score tracking
// Sequential double-dabble (one shift per clock), leading-zero blanking, session high score.
module score_bcd_display #(
    parameter int SCORE_W = 16,
    parameter int DIGITS  = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [SCORE_W-1:0] score,
    input  logic               show_high,
    output logic [6:0]         hex0,
    output logic [6:0]         hex1,
    output logic [6:0]         hex2,
    output logic [6:0]         hex3,
    output logic [6:0]         hex4,
    output logic [SCORE_W-1:0] high_score,
    output logic               new_high,
    output logic               busy
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int SH_W  = BCD_W + SCORE_W;
    localparam int CNT_W = $clog2(SCORE_W);

    typedef enum logic {S_IDLE = 1'b0, S_CONV = 1'b1} state_t;

    state_t               r_state;
    state_t               w_next;
    logic [SH_W-1:0]      r_shift;
    logic [CNT_W-1:0]     r_cnt;
    logic [SCORE_W-1:0]   r_captured;
    logic [SCORE_W-1:0]   r_shown;
    logic [BCD_W-1:0]     r_digits;
    logic [SCORE_W-1:0]   r_high;
    logic                 r_new_high;

    logic [SCORE_W-1:0]   w_sel;
    logic                 w_load;
    logic                 w_last;
    logic [SH_W-1:0]      w_adj;
    logic [SH_W-1:0]      w_shifted;
    logic [6:0]           w_seg   [DIGITS];
    logic [DIGITS-1:0]    w_blank;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    assign w_sel = show_high ? r_high : score;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_load) w_next = S_CONV;
            S_CONV:  if (w_last) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_load = (r_state == S_IDLE) && (w_sel != r_shown);
        w_last = (r_state == S_CONV) && (r_cnt == CNT_W'(SCORE_W - 1));
        busy   = (r_state == S_CONV);
    end

    // Add-3 to every BCD nibble >= 5 before the shift.
    always_comb begin
        w_adj = r_shift;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_shift[SCORE_W + 4*i +: 4] >= 4'd5)
                w_adj[SCORE_W + 4*i +: 4] = r_shift[SCORE_W + 4*i +: 4] + 4'd3;
        end
    end

    assign w_shifted = w_adj << 1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift    <= '0;
            r_cnt      <= '0;
            r_captured <= '0;
            r_shown    <= '0;
            r_digits   <= '0;
        end else if (w_load) begin
            r_shift    <= {{BCD_W{1'b0}}, w_sel};
            r_captured <= w_sel;
            r_cnt      <= '0;
        end else if (r_state == S_CONV) begin
            r_shift <= w_shifted;
            r_cnt   <= r_cnt + 1'b1;
            if (w_last) begin
                r_digits <= w_shifted[SH_W-1 -: BCD_W];
                r_shown  <= r_captured;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_high     <= '0;
            r_new_high <= 1'b0;
        end else if (score > r_high) begin
            r_high     <= score;
            r_new_high <= 1'b1;
        end else begin
            r_new_high <= 1'b0;
        end
    end

    // A digit blanks only when it and every more-significant digit are zero.
    always_comb begin
        for (int i = 0; i < DIGITS; i++) w_seg[i] = seg7(r_digits[4*i +: 4]);
        w_blank[DIGITS-1] = (r_digits[BCD_W-1 -: 4] == 4'd0);
        for (int i = DIGITS - 2; i >= 0; i--)
            w_blank[i] = w_blank[i+1] && (r_digits[4*i +: 4] == 4'd0);
    end

    assign hex0       = w_seg[0];
    assign hex1       = w_blank[1] ? 7'h7F : w_seg[1];
    assign hex2       = w_blank[2] ? 7'h7F : w_seg[2];
    assign hex3       = w_blank[3] ? 7'h7F : w_seg[3];
    assign hex4       = w_blank[4] ? 7'h7F : w_seg[4];
    assign high_score = r_high;
    assign new_high   = r_new_high;
endmodule

// File: tb/tb_score_bcd_display.sv
// tb/tb_score_bcd_display.sv - directed self-checking bench for score_bcd_display
module tb_score_bcd_display;
    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                           S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                           S6 = 7'b0000010, BL = 7'h7F;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] score;
    logic        show_high;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4;
    logic [15:0] high_score;
    logic        new_high;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;
    int cnt;

    score_bcd_display #(.SCORE_W(16), .DIGITS(5)) dut (
        .clk(clk), .reset(reset), .score(score), .show_high(show_high),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4),
        .high_score(high_score), .new_high(new_high), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_hex(input string tag, input logic [6:0] e4, input logic [6:0] e3,
                           input logic [6:0] e2, input logic [6:0] e1, input logic [6:0] e0);
        chk({tag, ".hex4"}, {25'd0, hex4}, {25'd0, e4});
        chk({tag, ".hex3"}, {25'd0, hex3}, {25'd0, e3});
        chk({tag, ".hex2"}, {25'd0, hex2}, {25'd0, e2});
        chk({tag, ".hex1"}, {25'd0, hex1}, {25'd0, e1});
        chk({tag, ".hex0"}, {25'd0, hex0}, {25'd0, e0});
    endtask

    task automatic wait_busy(input string tag, input logic level);
        int n = 0;
        while (busy !== level && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {31'd0, busy}, {31'd0, level});
    endtask

    task automatic count_busy(input int cycles, output int c);
        c = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (busy === 1'b1) c++;
        end
    endtask

    initial begin
        reset = 1'b1; score = 16'd0; show_high = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Idle after reset with score 0: no conversion.
        count_busy(20, cnt);
        chk("rst.busy_cycles", cnt, 0);
        chk_hex("rst", BL, BL, BL, BL, S0);
        chk("rst.high", {16'd0, high_score}, 32'd0);

        // Full-scale value.
        score = 16'd65535;
        count_busy(40, cnt);
        chk("max.busy_cycles", cnt, 16);
        chk_hex("max", S6, S5, S5, S3, S5);

        // Interior zeros shown.
        score = 16'd100;
        wait_busy("100.start", 1'b1);
        wait_busy("100.done", 1'b0);
        chk_hex("100", BL, BL, S1, S0, S0);

        // Change during conversion is deferred, then picked up.
        score = 16'd10;
        wait_busy("10.start", 1'b1);
        repeat (3) @(negedge clk);
        score = 16'd1500;
        wait_busy("10.done", 1'b0);
        chk_hex("10", BL, BL, BL, S1, S0);
        @(negedge clk);
        chk("1500.restart", {31'd0, busy}, 32'd1);
        wait_busy("1500.done", 1'b0);
        chk_hex("1500", BL, S1, S5, S0, S0);

        // High score tracking after a fresh reset.
        reset = 1'b1; score = 16'd0;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("hs.reset_high", {16'd0, high_score}, 32'd0);
        score = 16'd30;
        @(negedge clk);
        chk("hs.pulse", {31'd0, new_high}, 32'd1);
        chk("hs.high30", {16'd0, high_score}, 32'd30);
        @(negedge clk);
        chk("hs.pulse_end", {31'd0, new_high}, 32'd0);
        score = 16'd0;
        cnt = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (new_high === 1'b1) cnt++;
        end
        chk("hs.no_more_pulses", cnt, 0);
        chk("hs.persist", {16'd0, high_score}, 32'd30);
        chk_hex("hs.zero", BL, BL, BL, BL, S0);
        show_high = 1'b1;
        count_busy(40, cnt);
        chk("hs.busy_cycles", cnt, 16);
        chk_hex("hs.show30", BL, BL, BL, S3, S0);

        // Reset in the middle of a conversion.
        show_high = 1'b0;
        score = 16'd12345;
        wait_busy("abort.start", 1'b1);
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort.busy", {31'd0, busy}, 32'd0);
        chk("abort.high", {16'd0, high_score}, 32'd0);
        chk_hex("abort", BL, BL, BL, BL, S0);
        reset = 1'b0;
        count_busy(40, cnt);
        chk("redo.busy_cycles", cnt, 16);
        chk_hex("redo", S1, S2, S3, S4, S5);
        chk("redo.high", {16'd0, high_score}, 32'd12345);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/score_bcd_display.md
# score_bcd_display

Downstream display stage for the whack-a-mole game FSM. It takes the game's 16-bit binary `score` and converts it to five decimal digits with a sequential double-dabble engine, one shift per clock. The digits drive five active-low seven-segment displays with leading-zero blanking. The block also keeps a session high score, and the player can select either the live score or the high score for display.

## Interface
- `SCORE_W`, 16, binary score width; fixed pairing with `DIGITS`.
- `DIGITS`, 5, BCD digits; covers 0..65535.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `score`  input  16  live score from the game FSM; may change on any cycle.
- `show_high`  input  1  0 = display `score`, 1 = display `high_score`.
- `hex0`..`hex4`  output  7 each  active-low segments {g,f,e,d,c,b,a}; `hex0` is the least significant digit.
- `high_score`  output  16  largest `score` seen since reset.
- `new_high`  output  1  one-cycle pulse when `high_score` updates.
- `busy`  output  1  high while a conversion is in progress.

## Operation
- Display source: `sel = show_high ? high_score : score`, using the registered `high_score`.
- States:
  - IDLE: if `sel != shown_value`, load the shift register {20'b0, sel}, set `captured = sel`, clear `cnt`, and go to CONV. Otherwise stay in IDLE.
  - CONV: each cycle, add 3 to every BCD nibble ≥ 5, then shift the 36-bit register left by 1 and increment `cnt`.
  - On the 16th shift (`cnt == 15`), write the five resulting nibbles to the digit registers, set `shown_value = captured`, and go to IDLE.
- Changes to `sel` during CONV are ignored. IDLE re-evaluates on the cycle after completion and reconverts if `sel` differs, so the display always settles to the latest value.
- BCD nibbles are 4 bits; add-3 cannot overflow a nibble (max 9 → 12).
- Segment map: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- Leading-zero blanking:
  - A digit is blank (7'h7F) if it and every more-significant digit are 0.
  - `hex0` is never blanked.
  - Interior zeros are shown.
- High score:
  - Every cycle, in any state: if `score > high_score` (unsigned), then `high_score <= score` and `new_high <= 1`; else `new_high <= 0`.
  - `score` dropping to 0 at game start does not change `high_score`.
- Reset:
  - State → IDLE, `shown_value` = 0, digit registers = 0, `cnt` = 0.
  - Outputs: `hex0` = 1000000, `hex1`..`hex4` = 7'h7F, `busy` = 0, `high_score` = 0, `new_high` = 0.
  - Reset mid-conversion aborts the conversion. No partial result ever reaches the digit registers.

## Timing
- `busy` is the registered state (state == CONV).
- Load edge L: `busy` is high in cycles L+1..L+16.
- Digit registers, and therefore the `hex` outputs, update at edge L+16. Segment decode from the digit registers is combinational.
- Worst-case latency from a `sel` change to a correct display is 33 cycles: the change arrives one cycle after a load, waits out that conversion, then needs a full one.
- `new_high` is asserted the cycle after `score` exceeds `high_score`, together with the new `high_score` value.
- Toggling `show_high` is treated exactly like a value change. No conversion starts if both sources are equal to `shown_value`.

## Test plan
- Reset with `score`=0 held for 20 cycles → `hex0`=1000000, `hex1`..`hex4`=7F, `busy` never asserts, `high_score`=0.
- `score`=65535 → `busy` high for exactly 16 cycles. Then `hex4`=0000010 (6), `hex3`=0010010 (5), `hex2`=0010010 (5), `hex1`=0110000 (3), `hex0`=0010010 (5).
- `score`=100 → `hex2`=1111001, `hex1`=`hex0`=1000000, `hex3`=`hex4`=7F (interior zeros shown).
- `score`=10, then `score`=1500 four cycles after the load:
  - First result shows "10".
  - IDLE reconverts the next cycle.
  - Final display is `hex3`=1111001, `hex2`=0010010, `hex1`=`hex0`=1000000, `hex4`=7F.
- `score` 0→30→0:
  - `new_high` pulses once (one cycle) and `high_score`=30, which persists after `score` returns to 0.
  - Then `show_high`=1 → displays "30" after 16 busy cycles.
- `reset` asserted at cycle 8 of a conversion of 12345 → next cycle `busy`=0, display at reset values, `high_score`=0. After `reset` deasserts, 12345 is reconverted in full.
